gesture_pwm_sequencer: RTL and testbench

Tick-driven controller that sequences an LED PWM channel from the 2-bit hand-presence sensor. A debounced "present, withdraw" gesture arms the channel. After an arm delay it ramps the duty cycle up, holds at full brightness, then ramps back down. It also drives the red/green status LEDs and a busy/done status for the top level, and replaces the free-standing slow-clock FSM with a single-clock, clock-enable design.

---
 rtl/gesture_pwm_sequencer_if.sv | 25 ++
 rtl/gesture_pwm_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_gesture_pwm_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_pwm_sequencer_if.sv
// Hand-sensor / PWM status bundle between the sequencer and its host.
// Ports: hand, stop (host to sequencer); duty, pwm, r, g, busy, done (sequencer to host).
// master = host side, slave = sequencer side.
interface gesture_pwm_sequencer_if #(
   parameter int PWM_BITS = 8
);
   logic [1:0]          hand;
   logic                stop;
   logic [PWM_BITS-1:0] duty;
   logic                pwm;
   logic                r;
   logic                g;
   logic                busy;
   logic                done;

   modport master (
      output hand, stop,
      input  duty, pwm, r, g, busy, done
   );

   modport slave (
      input  hand, stop,
      output duty, pwm, r, g, busy, done
   );
endinterface

// File: rtl/gesture_pwm_sequencer.sv
// Purpose: debounced hand gesture arms an LED PWM channel, then ramps up, holds, ramps down.
// Latency: FSM/duty step once per prescaler tick; stop acts on the next clk; pwm lags pwm_cnt by 1 clk.
// Backpressure: none; stop is the only flow control and aborts the sequence.
// Ports: clk, reset (async active-low), bus.hand/bus.stop in; bus.duty/pwm/r/g/busy/done out.
module gesture_pwm_sequencer #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int TICK_HZ        = 100,
   parameter int PWM_BITS       = 8,
   parameter int RAMP_STEP      = 8,
   parameter int ARM_TICKS      = 50,
   parameter int HOLD_TICKS     = 300,
   parameter int DEBOUNCE_TICKS = 3
) (
   input logic                   clk,
   input logic                   reset,
   gesture_pwm_sequencer_if.slave bus
);

   localparam int PRESC_TC = CLK_HZ / TICK_HZ - 1;
   localparam int PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
   localparam int CNT_MAX  = (ARM_TICKS > HOLD_TICKS) ? ARM_TICKS : HOLD_TICKS;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam int STEP_W   = PWM_BITS + 1;

   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [STEP_W-1:0]   STEP_EXT = STEP_W'(RAMP_STEP);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PRESENT   = 3'd1;
   localparam logic [2:0] ARMED     = 3'd2;
   localparam logic [2:0] RAMP_UP   = 3'd3;
   localparam logic [2:0] HOLD      = 3'd4;
   localparam logic [2:0] RAMP_DOWN = 3'd5;

   logic [PRESC_W-1:0]  presc;
   logic                tick;
   logic [1:0]          hand_s1, hand_s2;
   logic [1:0]          hand_prev;
   logic [1:0]          hand_stable;
   logic [DEB_W-1:0]    deb_cnt;
   logic [2:0]          state;
   logic [CNT_W-1:0]    tick_cnt;
   logic [PWM_BITS-1:0] duty_q;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_q;
   logic                done_q;
   logic                stop_hit;
   logic [STEP_W-1:0]   duty_sum;
   logic [PWM_BITS-1:0] duty_up;
   logic [PWM_BITS-1:0] duty_dn;

   assign tick = (presc == PRESC_W'(PRESC_TC));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // The sensor is asynchronous to clk, so it is synchronised before the debouncer sees it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hand_s1 <= 2'b00;
         hand_s2 <= 2'b00;
      end else begin
         hand_s1 <= bus.hand;
         hand_s2 <= hand_s1;
      end
   end

   // deb_cnt counts consecutive equal tick samples beyond the first; the value is
   // accepted on the sample that brings the count to DEBOUNCE_TICKS-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hand_prev   <= 2'b00;
         hand_stable <= 2'b00;
         deb_cnt     <= '0;
      end else if (tick) begin
         hand_prev <= hand_s2;
         if (hand_s2 == hand_prev) begin
            if (deb_cnt != DEB_W'(DEBOUNCE_TICKS - 1)) begin
               deb_cnt <= deb_cnt + 1'b1;
            end
            if (deb_cnt >= DEB_W'(DEBOUNCE_TICKS - 2)) begin
               hand_stable <= hand_s2;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Ramp arithmetic is one bit wider than duty so the up-step saturates instead of wrapping.
   always_comb begin
      duty_sum = {1'b0, duty_q} + STEP_EXT;
      duty_up  = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[PWM_BITS-1:0];
      duty_dn  = '0;
      if ({1'b0, duty_q} >= STEP_EXT) begin
         duty_dn = duty_q - STEP_EXT[PWM_BITS-1:0];
      end
   end

   // stop only matters where it changes something; elsewhere the tick path runs normally.
   assign stop_hit = bus.stop &&
                     ((state == PRESENT) || (state == ARMED) ||
                      (state == RAMP_UP) || (state == HOLD));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         duty_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop_hit) begin
            // Abort: an active ramp/hold winds down from the current duty; pre-ramp states drop out.
            if ((state == RAMP_UP) || (state == HOLD)) begin
               state <= RAMP_DOWN;
            end else begin
               state <= IDLE;
            end
         end else if (tick) begin
            case (state)
               IDLE: begin
                  duty_q <= '0;
                  if (hand_stable == 2'b11) begin
                     state <= PRESENT;
                  end
               end
               PRESENT: begin
                  if (hand_stable == 2'b00) begin
                     state    <= ARMED;
                     tick_cnt <= '0;
                  end
               end
               ARMED: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  // Hand returning cancels the arm, even on the timeout tick.
                  if (hand_stable == 2'b11) begin
                     state <= IDLE;
                  end else if (tick_cnt == CNT_W'(ARM_TICKS - 1)) begin
                     state <= RAMP_UP;
                  end
               end
               RAMP_UP: begin
                  duty_q <= duty_up;
                  if (duty_up == DUTY_MAX) begin
                     state    <= HOLD;
                     tick_cnt <= '0;
                  end
               end
               HOLD: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == CNT_W'(HOLD_TICKS - 1)) begin
                     state <= RAMP_DOWN;
                  end
               end
               RAMP_DOWN: begin
                  duty_q <= duty_dn;
                  if (duty_dn == '0) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt <= '0;
         pwm_q   <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         pwm_q   <= (pwm_cnt < duty_q);
      end
   end

   assign bus.duty = duty_q;
   assign bus.pwm  = pwm_q;
   assign bus.done = done_q;
   assign bus.r    = (state == IDLE) || (state == ARMED) || (state == RAMP_DOWN);
   assign bus.g    = (state == RAMP_UP) || (state == HOLD) || (state == RAMP_DOWN);
   assign bus.busy = (state == RAMP_UP) || (state == HOLD) || (state == RAMP_DOWN);

endmodule

// File: tb/tb_gesture_pwm_sequencer.sv
// Testbench for gesture_pwm_sequencer: tick every 10 clks, RAMP_STEP=64, ARM=4, HOLD=5, DEBOUNCE=3.
// Duty changes are captured by a monitor and scored against per-test expected queues.
module tb_gesture_pwm_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   gesture_pwm_sequencer_if #(.PWM_BITS(8)) ifc ();

   gesture_pwm_sequencer #(
      .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(8), .RAMP_STEP(64),
      .ARM_TICKS(4), .HOLD_TICKS(5), .DEBOUNCE_TICKS(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(ifc)
   );

   int total = 0;
   int bad   = 0;

   // Bench-side time base: tick phase and free-running PWM counter since reset release.
   logic [3:0] tb_presc;
   logic [7:0] tb_pcnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         tb_presc <= 4'd0;
         tb_pcnt  <= 8'd0;
      end else begin
         tb_presc <= (tb_presc == 4'd9) ? 4'd0 : tb_presc + 4'd1;
         tb_pcnt  <= tb_pcnt + 8'd1;
      end
   end

   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] last_duty = 8'd0;
   int         done_cnt  = 0;
   always @(negedge clk) begin
      if (ifc.duty !== last_duty) obs_q.push_back(ifc.duty);
      last_duty = ifc.duty;
      if (ifc.done === 1'b1) done_cnt++;
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int guard;
         guard = 0;
         do begin
            @(posedge clk);
            #1;
            guard++;
         end while (tb_presc != 4'd0 && guard < 20);
      end
   endtask

   task automatic pulse_stop();
      ifc.stop = 1'b1;
      @(posedge clk);
      #1;
      ifc.stop = 1'b0;
   endtask

   // Stimulus only: from IDLE with a settled 00 hand, ends just after the tick entering ARMED.
   task automatic drive_gesture();
      ifc.hand = 2'b11;
      wait_ticks(4);
      ifc.hand = 2'b00;
      wait_ticks(4);
   endtask

   task automatic test_reset();
      int first;
      ifc.hand = 2'b00;
      ifc.stop = 1'b0;
      #2 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (ifc.duty !== 8'd0 || ifc.pwm !== 1'b0) begin
         bad++; $display("FAIL reset_held duty=%0d pwm=%b required 0/0", ifc.duty, ifc.pwm);
      end
      @(negedge clk) reset = 1'b1;
      #1;
      total++;
      if ({ifc.r, ifc.g, ifc.busy, ifc.done, ifc.pwm} !== 5'b10000) begin
         bad++; $display("FAIL reset_flags rgbdp=%b required 10000",
                         {ifc.r, ifc.g, ifc.busy, ifc.done, ifc.pwm});
      end
      total++;
      if (ifc.duty !== 8'd0) begin
         bad++; $display("FAIL reset_duty got=%0d required=0", ifc.duty);
      end
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (dut.tick === 1'b1) begin
            first = i + 1;
            break;
         end
      end
      total++;
      if (first != 10) begin
         bad++; $display("FAIL reset_first_tick clk=%0d required=10", first);
      end
      wait_ticks(1);
   endtask

   task automatic test_full_sequence();
      logic [7:0] ramp [8] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0};
      logic [2:0] chk_rgb [9] = '{3'b100, 3'b000, 3'b100, 3'b100, 3'b011, 3'b011, 3'b011, 3'b111, 3'b100};
      int         steps   [9] = '{3, 1, 6, 3, 1, 4, 4, 1, 4};
      int rd, d0;
      logic [7:0] e;
      rd = obs_q.size();
      d0 = done_cnt;
      foreach (ramp[i]) exp_q.push_back(ramp[i]);
      ifc.hand = 2'b11;
      for (int k = 0; k < 9; k++) begin
         if (k == 2) begin
            wait_ticks(2);
            ifc.hand = 2'b00;
            wait_ticks(4);
         end else begin
            wait_ticks(steps[k]);
         end
         total++;
         if ({ifc.r, ifc.g, ifc.busy} !== chk_rgb[k]) begin
            bad++; $display("FAIL full_state[%0d] rgbusy=%b required=%b", k,
                            {ifc.r, ifc.g, ifc.busy}, chk_rgb[k]);
         end
      end
      wait_ticks(1);
      total++;
      if (done_cnt - d0 != 1) begin
         bad++; $display("FAIL full_done_pulses got=%0d required=1", done_cnt - d0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (rd >= obs_q.size()) begin
            bad++; $display("FAIL full_duty missing required=%0d", e);
         end else begin
            if (obs_q[rd] !== e) begin
               bad++; $display("FAIL full_duty[%0d] got=%0d required=%0d", rd, obs_q[rd], e);
            end
            rd++;
         end
      end
      total++;
      if (obs_q.size() != rd) begin
         bad++; $display("FAIL full_duty_extra got=%0d required=0", obs_q.size() - rd);
      end
   endtask

   task automatic test_debounce();
      int rd;
      rd = obs_q.size();
      for (int i = 0; i < 7; i++) begin
         if (i == 0) ifc.hand = 2'b11;
         if (i == 2) ifc.hand = 2'b00;
         wait_ticks(1);
         total++;
         if (dut.hand_stable === 2'b11 || {ifc.r, ifc.g, ifc.busy} !== 3'b100) begin
            bad++; $display("FAIL debounce_tick[%0d] stable=%b rgbusy=%b required stable!=11 rgbusy=100",
                            i, dut.hand_stable, {ifc.r, ifc.g, ifc.busy});
         end
      end
      total++;
      if (obs_q.size() != rd) begin
         bad++; $display("FAIL debounce_duty changes=%0d required=0", obs_q.size() - rd);
      end
   endtask

   task automatic test_arm_cancel();
      int rd;
      rd = obs_q.size();
      drive_gesture();
      ifc.hand = 2'b11;
      wait_ticks(4);
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b100 || ifc.duty !== 8'd0) begin
         bad++; $display("FAIL cancel_idle rgbusy=%b duty=%0d required 100/0",
                         {ifc.r, ifc.g, ifc.busy}, ifc.duty);
      end
      ifc.hand = 2'b00;
      wait_ticks(1);
      // Only IDLE moves to PRESENT; an un-cancelled ARMED would have started ramping.
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b000) begin
         bad++; $display("FAIL cancel_present rgbusy=%b required=000", {ifc.r, ifc.g, ifc.busy});
      end
      wait_ticks(2);
      pulse_stop();
      wait_ticks(2);
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b100) begin
         bad++; $display("FAIL cancel_stop_idle rgbusy=%b required=100", {ifc.r, ifc.g, ifc.busy});
      end
      total++;
      if (obs_q.size() != rd) begin
         bad++; $display("FAIL cancel_duty changes=%0d required=0", obs_q.size() - rd);
      end
   endtask

   task automatic test_abort();
      logic [7:0] ramp [8] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0};
      int rd, d0;
      logic [7:0] e;
      rd = obs_q.size();
      d0 = done_cnt;
      foreach (ramp[i]) exp_q.push_back(ramp[i]);
      drive_gesture();
      wait_ticks(9);
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b011 || ifc.duty !== 8'd255) begin
         bad++; $display("FAIL abort_hold rgbusy=%b duty=%0d required 011/255",
                         {ifc.r, ifc.g, ifc.busy}, ifc.duty);
      end
      pulse_stop();
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b111 || ifc.duty !== 8'd255) begin
         bad++; $display("FAIL abort_ramp_down rgbusy=%b duty=%0d required 111/255",
                         {ifc.r, ifc.g, ifc.busy}, ifc.duty);
      end
      wait_ticks(4);
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b100) begin
         bad++; $display("FAIL abort_idle rgbusy=%b required=100", {ifc.r, ifc.g, ifc.busy});
      end
      wait_ticks(1);
      total++;
      if (done_cnt - d0 != 1) begin
         bad++; $display("FAIL abort_done_pulses got=%0d required=1", done_cnt - d0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (rd >= obs_q.size()) begin
            bad++; $display("FAIL abort_duty missing required=%0d", e);
         end else begin
            if (obs_q[rd] !== e) begin
               bad++; $display("FAIL abort_duty[%0d] got=%0d required=%0d", rd, obs_q[rd], e);
            end
            rd++;
         end
      end
      d0 = done_cnt;
      pulse_stop();
      wait_ticks(2);
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b100 || done_cnt != d0 || obs_q.size() != rd) begin
         bad++; $display("FAIL stop_in_idle rgbusy=%b dones=%0d changes=%0d required 100/0/0",
                         {ifc.r, ifc.g, ifc.busy}, done_cnt - d0, obs_q.size() - rd);
      end
   endtask

   task automatic test_pwm();
      int rd, d0, highs, shape_bad;
      logic [7:0] prev_cnt;
      logic       exp_p;
      logic [7:0] e;
      rd = obs_q.size();
      d0 = done_cnt;
      exp_q.push_back(8'd64);
      exp_q.push_back(8'd0);
      drive_gesture();
      wait_ticks(5);
      pulse_stop();
      total++;
      if ({ifc.r, ifc.g, ifc.busy} !== 3'b111 || ifc.duty !== 8'd64) begin
         bad++; $display("FAIL pwm_stop_ramp_up rgbusy=%b duty=%0d required 111/64",
                         {ifc.r, ifc.g, ifc.busy}, ifc.duty);
      end
      force dut.duty_q = 8'd64;
      wait_ticks(1);
      highs = 0;
      shape_bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         prev_cnt = tb_pcnt - 8'd1;
         exp_p = (prev_cnt < 8'd64);
         if (ifc.pwm === 1'b1) highs++;
         if (ifc.pwm !== exp_p) shape_bad++;
      end
      total++;
      if (highs != 64) begin
         bad++; $display("FAIL pwm_high_count got=%0d required=64", highs);
      end
      total++;
      if (shape_bad != 0) begin
         bad++; $display("FAIL pwm_lag_shape wrong_clks=%0d required=0", shape_bad);
      end
      release dut.duty_q;
      wait_ticks(2);
      total++;
      if (done_cnt - d0 != 1 || ifc.duty !== 8'd0) begin
         bad++; $display("FAIL pwm_end dones=%0d duty=%0d required 1/0", done_cnt - d0, ifc.duty);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (rd >= obs_q.size()) begin
            bad++; $display("FAIL pwm_duty missing required=%0d", e);
         end else begin
            if (obs_q[rd] !== e) begin
               bad++; $display("FAIL pwm_duty[%0d] got=%0d required=%0d", rd, obs_q[rd], e);
            end
            rd++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_debounce();
      test_arm_cancel();
      test_abort();
      test_pwm();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
